// File: rtl/i2s_capture_controller.sv
// I2S master sck/ws generator with mic warmup gating and left/right pairing; I2S_WARMUP_EN selects multi-frame warmup.
// Latency: pair_valid one clk after the right-word rx_valid; no backpressure, receiver words are never stalled.
module i2s_capture_controller #(
    parameter int SCK_DIV       = 16,
    parameter int SLOT_BITS     = 32,
    parameter int DATA_WIDTH    = 24,
    parameter int WARMUP_FRAMES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    output logic                         sck,
    output logic                         ws,
    input  logic signed [DATA_WIDTH-1:0] rx_data,
    input  logic                         rx_valid,
    output logic signed [DATA_WIDTH-1:0] left_out,
    output logic signed [DATA_WIDTH-1:0] right_out,
    output logic                         pair_valid,
    output logic                         running,
    output logic                         warm
);
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(2 * SLOT_BITS) : 1;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]             bit_cnt_q, bit_cnt_d;
    logic                         sck_q, sck_d;
    logic                         ws_q, ws_d;
    logic                         drain_wrap_q, drain_wrap_d;
    logic                         left_have_q, left_have_d;
    logic signed [DATA_WIDTH-1:0] hold_q, hold_d;
    logic signed [DATA_WIDTH-1:0] left_q, left_d;
    logic signed [DATA_WIDTH-1:0] right_q, right_d;
    logic                         pair_vld_q, pair_vld_d;
    logic                         running_q, running_d;
    logic                         warm_q, warm_d;

    logic                         div_wrap;
    logic                         sck_fall;
    logic                         bit_last;
    logic                         frame_wrap;
    logic                         warmup_done;
    logic [BIT_W-1:0]             bit_inc;

`ifdef I2S_WARMUP_EN
    localparam int FRM_W = $clog2(WARMUP_FRAMES + 1);
    logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
    assign warmup_done = (frame_cnt_q == FRM_W'(WARMUP_FRAMES - 1));
`else
    localparam int warmup_frames_unused = WARMUP_FRAMES;
    assign warmup_done = 1'b1;
`endif

    assign div_wrap   = (div_cnt_q == DIV_W'(SCK_DIV - 1));
    assign sck_fall   = (state_q != IDLE) && div_wrap && sck_q;
    assign bit_last   = (bit_cnt_q == BIT_W'(2 * SLOT_BITS - 1));
    assign bit_inc    = bit_last ? '0 : bit_cnt_q + BIT_W'(1);
    assign frame_wrap = sck_fall && bit_last;

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        sck_d        = sck_q;
        ws_d         = ws_q;
        drain_wrap_d = drain_wrap_q;
        left_have_d  = left_have_q;
        hold_d       = hold_q;
        left_d       = left_q;
        right_d      = right_q;
        pair_vld_d   = 1'b0;
        running_d    = running_q;
        warm_d       = warm_q;
`ifdef I2S_WARMUP_EN
        frame_cnt_d  = frame_cnt_q;
        if (state_q == IDLE) begin
            frame_cnt_d = '0;
        end else if (state_q == WARMUP && frame_wrap && frame_cnt_q != FRM_W'(WARMUP_FRAMES)) begin
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
        end
`endif

        if (state_q != IDLE) begin
            div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
            if (div_wrap) begin
                sck_d = ~sck_q;
            end
            // ws is derived from the post-edge bit count so it only moves with sck falling
            if (sck_fall) begin
                bit_cnt_d = bit_inc;
                ws_d      = (bit_inc >= BIT_W'(SLOT_BITS));
            end
        end

        if ((state_q == RUN || state_q == DRAIN) && rx_valid) begin
            if (ws_q) begin
                hold_d      = rx_data;
                left_have_d = 1'b1;
            end else if (left_have_q) begin
                left_d      = hold_q;
                right_d     = rx_data;
                pair_vld_d  = 1'b1;
                left_have_d = 1'b0;
            end
        end

        case (state_q)
            IDLE: begin
                div_cnt_d = '0;
                bit_cnt_d = '0;
                sck_d     = 1'b0;
                ws_d      = 1'b0;
                if (enable) begin
                    state_d = WARMUP;
                end
            end
            WARMUP, RUN: begin
                if (!enable) begin
                    state_d      = DRAIN;
                    drain_wrap_d = 1'b0;
                end else if (state_q == WARMUP && frame_wrap && warmup_done) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (frame_wrap) begin
                    drain_wrap_d = 1'b1;
                end
                // two sck periods past the wrap the receiver has shifted out the last right word
                if (sck_fall && drain_wrap_q && bit_inc == BIT_W'(2)) begin
                    state_d     = IDLE;
                    div_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    sck_d       = 1'b0;
                    ws_d        = 1'b0;
                    left_have_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d != IDLE);
        warm_d    = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            sck_q        <= 1'b0;
            ws_q         <= 1'b0;
            drain_wrap_q <= 1'b0;
            left_have_q  <= 1'b0;
            hold_q       <= '0;
            left_q       <= '0;
            right_q      <= '0;
            pair_vld_q   <= 1'b0;
            running_q    <= 1'b0;
            warm_q       <= 1'b0;
`ifdef I2S_WARMUP_EN
            frame_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            sck_q        <= sck_d;
            ws_q         <= ws_d;
            drain_wrap_q <= drain_wrap_d;
            left_have_q  <= left_have_d;
            hold_q       <= hold_d;
            left_q       <= left_d;
            right_q      <= right_d;
            pair_vld_q   <= pair_vld_d;
            running_q    <= running_d;
            warm_q       <= warm_d;
`ifdef I2S_WARMUP_EN
            frame_cnt_q  <= frame_cnt_d;
`endif
        end
    end

    assign sck        = sck_q;
    assign ws         = ws_q;
    assign left_out   = left_q;
    assign right_out  = right_q;
    assign pair_valid = pair_vld_q;
    assign running    = running_q;
    assign warm       = warm_q;

endmodule

// File: tb/tb_i2s_capture_controller.sv
// Directed bench for i2s_capture_controller: SCK_DIV=2, SLOT_BITS=8, WARMUP_FRAMES=3 (64-clk frames).
module tb_i2s_capture_controller;
    localparam int DW = 24;
`ifdef I2S_WARMUP_EN
    localparam int WARM_CLK = 192;
`else
    localparam int WARM_CLK = 64;
`endif

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          sck;
    logic          ws;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          pair_valid;
    logic          running;
    logic          warm;

    int n;
    int n_checks;
    int n_pass;

    i2s_capture_controller #(
        .SCK_DIV      (2),
        .SLOT_BITS    (8),
        .DATA_WIDTH   (DW),
        .WARMUP_FRAMES(3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sck       (sck),
        .ws        (ws),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .left_out  (left_out),
        .right_out (right_out),
        .pair_valid(pair_valid),
        .running   (running),
        .warm      (warm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // n counts clk edges since the most recent WARMUP entry
    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic goto(input int p);
        for (int i = 0; i < 64; i++) begin
            if ((n % 64) == p) break;
            step();
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        rx_data  = d;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n        = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        #12;
        check("rst_sck",        32'(sck),        32'd0);
        check("rst_ws",         32'(ws),         32'd0);
        check("rst_running",    32'(running),    32'd0);
        check("rst_warm",       32'(warm),       32'd0);
        check("rst_pair_valid", 32'(pair_valid), 32'd0);
        check("rst_left",       32'(left_out),   32'd0);
        check("rst_right",      32'(right_out),  32'd0);
        rst_n = 1'b1;
        step();
        step();
        check("idle_sck",     32'(sck),     32'd0);
        check("idle_running", 32'(running), 32'd0);

        enable = 1'b1;
        step();
        n = 0;
        check("entry_running", 32'(running), 32'd1);
        check("entry_warm",    32'(warm),    32'd0);
        check("entry_sck",     32'(sck),     32'd0);

        // warmup words (one right, one left) must never produce a pair
        for (int k = 0; k < 200; k++) begin
            rx_data  = 24'h00AA55;
            rx_valid = (n == 10 || n == 40);
            step();
            check("clk_sck",  32'(sck),        32'((n / 2) % 2));
            check("clk_ws",   32'(ws),         32'((n / 32) % 2));
            check("warm",     32'(warm),       32'(n >= WARM_CLK));
            check("warm_pv",  32'(pair_valid), 32'd0);
        end
        rx_valid = 1'b0;

        goto(10);
        send(24'h000111);
        check("orphan_pv",    32'(pair_valid), 32'd0);
        check("orphan_left",  32'(left_out),   32'd0);
        check("orphan_right", 32'(right_out),  32'd0);
        step();
        check("orphan_pv2",   32'(pair_valid), 32'd0);

        goto(40);
        send(24'h123456);
        check("left_only_pv", 32'(pair_valid), 32'd0);
        goto(10);
        send(24'hABCDEF);
        check("pair_pv",    32'(pair_valid), 32'd1);
        check("pair_left",  32'(left_out),   32'h123456);
        check("pair_right", 32'(right_out),  32'hABCDEF);
        step();
        check("pair_pulse_end", 32'(pair_valid), 32'd0);
        check("pair_hold_left", 32'(left_out),   32'h123456);

        goto(36);
        send(24'h000001);
        goto(44);
        send(24'h000002);
        goto(8);
        send(24'h000003);
        check("dbl_pv",    32'(pair_valid), 32'd1);
        check("dbl_left",  32'(left_out),   32'h000002);
        check("dbl_right", 32'(right_out),  32'h000003);
        step();

        // drop enable while bit_cnt = 5
        goto(21);
        enable = 1'b0;
        step();
        check("drain_running", 32'(running), 32'd1);
        check("drain_warm",    32'(warm),    32'd0);
        goto(40);
        send(24'h0A0A0A);
        goto(2);
        send(24'h0B0B0B);
        check("drain_pv",    32'(pair_valid), 32'd1);
        check("drain_left",  32'(left_out),   32'h0A0A0A);
        check("drain_right", 32'(right_out),  32'h0B0B0B);
        goto(7);
        check("drain_sck_last",  32'(sck),     32'd1);
        check("drain_run_last",  32'(running), 32'd1);
        step();
        check("stop_running", 32'(running), 32'd0);
        check("stop_sck",     32'(sck),     32'd0);
        check("stop_ws",      32'(ws),      32'd0);
        step();
        step();
        check("stopped_sck",     32'(sck),     32'd0);
        check("stopped_running", 32'(running), 32'd0);

        // mid-frame asynchronous reset
        enable = 1'b1;
        step();
        n = 0;
        goto(40);
        check("pre_rst_ws",      32'(ws),      32'd1);
        check("pre_rst_running", 32'(running), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ws",      32'(ws),       32'd0);
        check("arst_running", 32'(running),  32'd0);
        check("arst_left",    32'(left_out), 32'd0);
        check("arst_right",   32'(right_out),32'd0);
        enable = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_running", 32'(running), 32'd0);
        check("post_rst_sck",     32'(sck),     32'd0);
        enable = 1'b1;
        step();
        n = 0;
        check("restart_running", 32'(running), 32'd1);
        step();
        check("restart_sck_n1", 32'(sck), 32'd0);
        step();
        check("restart_sck_n2", 32'(sck), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
